// File: rtl/reg_n.sv
// reg_n: N-bit storage register with a synchronous write enable and an
// asynchronous active-high clear that loads RESET_VAL.
module reg_n #(
   parameter int           N         = 32,
   parameter logic [N-1:0] RESET_VAL = '0
) (
   input  logic [N-1:0] DataIn,
   input  logic         clk,
   input  logic         regWE,
   input  logic         CLR,
   output logic [N-1:0] DataOut
);
   logic [N-1:0] data_q, data_d;
   assign data_d = regWE ? DataIn : data_q;
   always_ff @(posedge clk or posedge CLR)
      if (CLR) data_q <= RESET_VAL;
      else     data_q <= data_d;
   assign DataOut = data_q;
endmodule

// File: tb/tb_reg_n.sv
// tb_reg_n: directed checks of reg_n at the default 32-bit width and at
// N=8 with a non-zero clear value.
module tb_reg_n;
   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic [31:0] din = 32'h0;
   logic        we = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] dout;
   logic [7:0]  din8 = 8'h0;
   logic        we8 = 1'b0;
   logic        clr8 = 1'b0;
   logic [7:0]  dout8;
   int          n_checks = 0;
   int          n_fail = 0;

   reg_n dut32 (.DataIn(din), .clk(clk), .regWE(we), .CLR(clr), .DataOut(dout));
   reg_n #(.N(8), .RESET_VAL(8'h5A)) dut8 (
      .DataIn(din8), .clk(clk), .regWE(we8), .CLR(clr8), .DataOut(dout8));

   // The clock is held low until clk_en so the first clear has no edge.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      // 1: clear pulse with no clock edge
      din = 32'hAB; we = 1'b1; clr = 1'b1;
      #2 check("clr_async", dout, 32'h0);
      #8 check("clr_hold", dout, 32'h0);
      // 2: release clear, load on first edge only
      clr = 1'b0;
      #1 check("release_no_edge", dout, 32'h0);
      clk_en = 1'b1;
      tick();
      check("write_ab", dout, 32'hAB);
      // 3: hold with regWE low
      we = 1'b0; din = 32'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_ab", dout, 32'hAB);
      end
      din = 32'h55;
      #2 check("din_between_edges", dout, 32'hAB);
      // 4: clear mid-cycle, clear wins over write, then first edge after release loads
      tick();
      we = 1'b1; din = 32'hFFFFFFFF;
      #1 check("pre_clr", dout, 32'hAB);
      clr = 1'b1;
      #1 check("clr_midcycle", dout, 32'h0);
      tick();
      check("clr_wins_edge1", dout, 32'h0);
      tick();
      check("clr_wins_edge2", dout, 32'h0);
      clr = 1'b0;
      #1 check("clr_fall_no_edge", dout, 32'h0);
      tick();
      check("load_after_clr", dout, 32'hFFFFFFFF);
      // 5: back-to-back writes
      din = 32'h12345678;
      tick();
      check("b2b_1", dout, 32'h12345678);
      din = 32'h87654321;
      tick();
      check("b2b_2", dout, 32'h87654321);
      // 6: N=8 instance with RESET_VAL 8'h5A
      din8 = 8'hC3; we8 = 1'b1; clr8 = 1'b1;
      #1 check("n8_clear", {24'h0, dout8}, 32'h5A);
      tick();
      check("n8_clear_edge", {24'h0, dout8}, 32'h5A);
      clr8 = 1'b0;
      tick();
      check("n8_write", {24'h0, dout8}, 32'hC3);
      we8 = 1'b0; din8 = 8'h00;
      tick();
      check("n8_hold", {24'h0, dout8}, 32'hC3);
      check("n32_unaffected", dout, 32'h87654321);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
